// File: rtl/pwm_tick_engine.sv
// Purpose : tick generator (one-cycle `zero` every PERIOD enabled clocks) plus
//           counter-compare PWM with a duty register latched once per period.
// Latency : outputs are combinational from registered state, gated by enable;
//           duty_cycle changes apply at the next PWM period start.
// Backpressure: none; free-running while enable=1, frozen/cleared while enable=0.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset (0 = in reset)
//   enable     - run enable for both counters
//   duty_cycle - requested PWM high time in clocks per 2^WIDTH period
//   zero       - one-cycle tick when the down-counter is at 0 while enabled
//   pwm_out    - PWM output
module pwm_tick_engine #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 3_906_250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             zero,
  output logic             pwm_out
);

  if (PERIOD < 1) begin : g_period_check
    $error("pwm_tick_engine: PERIOD must be >= 1");
  end

  localparam int               DC_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DC_W-1:0]  DC_RELOAD = DC_W'(PERIOD - 1);
  localparam logic [WIDTH-1:0] PWM_MAX   = '1;

  logic [DC_W-1:0]  dc_count;
  logic [WIDTH-1:0] pwm_count;
  logic [WIDTH-1:0] duty_reg;
  logic             duty_load;

  // Tick down-counter: frozen (not reloaded) while disabled, so a paused
  // interval resumes where it left off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dc_count <= DC_RELOAD;
    end else if (enable) begin
      if (dc_count == '0) begin
        dc_count <= DC_RELOAD;
      end else begin
        dc_count <= dc_count - 1'b1;
      end
    end
  end

  // PWM counter: wraps naturally at 2^WIDTH; cleared while disabled so every
  // enable starts a fresh period at count 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_count <= '0;
    end else if (enable) begin
      pwm_count <= pwm_count + 1'b1;
    end else begin
      pwm_count <= '0;
    end
  end

  // Duty is sampled only on the last count of a period (or continuously while
  // disabled) so the compare value never changes mid-period.
  assign duty_load = !enable || (pwm_count == PWM_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_reg <= '0;
    end else if (duty_load) begin
      duty_reg <= duty_cycle;
    end
  end

  // Gating with reset keeps both outputs low during reset even when PERIOD=1,
  // where the reset value of dc_count is already 0.
  assign zero    = reset & enable & (dc_count == '0);
  assign pwm_out = reset & enable & (pwm_count < duty_reg);

endmodule

// File: tb/tb_pwm_tick_engine.sv
// Purpose : directed self-checking bench for pwm_tick_engine (WIDTH=8, PERIOD=4),
//           with a second PERIOD=1 instance for the degenerate tick case.
// Latency : inputs driven 1 time unit after posedge, outputs sampled 3 units after.
// Backpressure: n/a.
module tb_pwm_tick_engine;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] duty_cycle;
  logic       zero;
  logic       pwm_out;
  logic       zero1;
  logic       pwm_out1;

  int checks   = 0;
  int failures = 0;

  pwm_tick_engine #(.WIDTH(8), .PERIOD(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .duty_cycle (duty_cycle),
    .zero       (zero),
    .pwm_out    (pwm_out)
  );

  pwm_tick_engine #(.WIDTH(4), .PERIOD(1)) u_dut_p1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .duty_cycle (duty_cycle[3:0]),
    .zero       (zero1),
    .pwm_out    (pwm_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One disabled window loads duty_reg and clears pwm_count; returns inside
  // the first enabled window (pwm_count=0), before its sample point.
  task automatic start_pwm(input logic [7:0] d);
    next_cycle();
    enable     = 1'b0;
    duty_cycle = d;
    next_cycle();
    enable     = 1'b1;
  endtask

  initial begin
    int ticks;
    int highs;
    int highs1;
    int mism;
    int zmism;
    logic s255;
    logic first;
    logic s256;

    reset      = 1'b0;
    enable     = 1'b1;
    duty_cycle = 8'd0;

    // Reset held with enable=1: everything low, including the PERIOD=1 tick.
    next_cycle();
    settle();
    chk("rst_zero", zero, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_zero_p1", zero1, 0);

    // Tick spacing: high on enabled cycles 4, 8, 12, 16 after release.
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      if (k == 1) reset = 1'b1;
      settle();
      chk($sformatf("tick_c%0d", k), zero, (k % 4 == 0) ? 1 : 0);
      if (k == 1) chk("p1_zero_en", zero1, 1);
    end

    // Cycle 17 has dc_count=3, cycle 18 has dc_count=2; disable there.
    next_cycle();
    settle();
    chk("tick_c17", zero, 0);
    next_cycle();
    enable = 1'b0;
    settle();
    chk("gate_off_zero", zero, 0);
    chk("gate_off_p1", zero1, 0);
    ticks = 0;
    for (int j = 0; j < 9; j++) begin
      next_cycle();
      settle();
      ticks += int'(zero);
    end
    chk("gate_ticks", ticks, 0);
    for (int j = 1; j <= 4; j++) begin
      next_cycle();
      if (j == 1) enable = 1'b1;
      settle();
      chk($sformatf("reen_tick_c%0d", j), zero, (j == 3) ? 1 : 0);
    end

    // Duty 0: never high.
    start_pwm(8'd0);
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) next_cycle();
      settle();
      highs += int'(pwm_out);
    end
    chk("duty0_highs", highs, 0);

    // Duty 255: 255 high, 1 low per period.
    start_pwm(8'd255);
    highs = 0;
    mism  = 0;
    s255  = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) next_cycle();
      settle();
      highs += int'(pwm_out);
      if (pwm_out !== ((i % 256) < 255)) mism++;
      if (i == 255) s255 = pwm_out;
    end
    chk("duty255_highs", highs, 510);
    chk("duty255_pattern", mism, 0);
    chk("duty255_low_at_max", s255, 0);

    // Duty 64: 64 high then 192 low.
    start_pwm(8'd64);
    highs = 0;
    mism  = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) next_cycle();
      settle();
      highs += int'(pwm_out);
      if (pwm_out !== (i < 64)) mism++;
    end
    chk("duty64_highs", highs, 64);
    chk("duty64_pattern", mism, 0);

    // Mid-period change 100 -> 30 at pwm_count=50.
    start_pwm(8'd100);
    highs  = 0;
    highs1 = 0;
    mism   = 0;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) next_cycle();
      if (i == 50) duty_cycle = 8'd30;
      settle();
      if (i < 256) highs += int'(pwm_out);
      else         highs1 += int'(pwm_out);
      if (pwm_out !== ((i < 256) ? (i < 100) : ((i - 256) < 30))) mism++;
    end
    chk("mid_p0_highs", highs, 100);
    chk("mid_p1_highs", highs1, 30);
    chk("mid_pattern", mism, 0);

    // Disable/re-enable with duty 128 in the middle of a period.
    start_pwm(8'd128);
    for (int i = 0; i < 70; i++) next_cycle();
    highs = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) next_cycle();
      if (j == 0) enable = 1'b0;
      settle();
      highs += int'(pwm_out);
    end
    chk("dis_pwm_highs", highs, 0);
    next_cycle();
    enable = 1'b1;
    highs  = 0;
    mism   = 0;
    first  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) next_cycle();
      settle();
      if (i == 0) first = pwm_out;
      highs += int'(pwm_out);
      if (pwm_out !== (i < 128)) mism++;
    end
    chk("reen_first_pwm", first, 1);
    chk("reen_highs", highs, 128);
    chk("reen_pattern", mism, 0);

    // Async reset mid-run: reach pwm_count=200 with dc_count=1.
    next_cycle();
    duty_cycle = 8'd255;
    reset      = 1'b0;
    settle();
    chk("rst2_pwm", pwm_out, 0);
    next_cycle();
    reset = 1'b1;                 // dc=3, pc=0
    next_cycle();                 // dc=2, pc=1
    next_cycle();                 // dc=1, pc=2
    enable = 1'b0;                // pc clears, dc holds 1, duty_reg=255
    next_cycle();
    enable = 1'b1;                // dc=1, pc=0
    repeat (200) next_cycle();    // dc=1, pc=200
    settle();
    chk("pre_rst_pwm", pwm_out, 1);
    chk("pre_rst_zero", zero, 0);
    chk("pre_rst_p1", zero1, 1);
    reset = 1'b0;
    #1;
    chk("async_pwm", pwm_out, 0);
    chk("async_zero", zero, 0);
    chk("async_zero_p1", zero1, 0);

    // After release: pwm_count from 0 with duty_reg=0 for one period, then
    // duty 255; ticks restart from PERIOD-1.
    next_cycle();
    reset = 1'b1;
    highs = 0;
    mism  = 0;
    zmism = 0;
    s256  = 1'b0;
    for (int i = 0; i < 260; i++) begin
      if (i > 0) next_cycle();
      settle();
      highs += int'(pwm_out);
      if (pwm_out !== (i >= 256)) mism++;
      if (zero !== ((i + 1) % 4 == 0)) zmism++;
      if (i == 256) s256 = pwm_out;
    end
    chk("post_rst_pwm_highs", highs, 4);
    chk("post_rst_pwm_pattern", mism, 0);
    chk("post_rst_zero_pattern", zmism, 0);
    chk("post_rst_pwm_at_256", s256, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
